// File: rtl/riscv_privileged_pkg.sv
// Shared M-mode CSR types, address map and write masks for the CSR responder slice.
// The optional mtinst/mtval2 registers are controlled by CSR_MTINST_MTVAL2_EN in the top.
package riscv_privileged_pkg;

   typedef enum logic [1:0] {
      PRIV_USER       = 2'b00,
      PRIV_SUPERVISOR = 2'b01,
      PRIV_MACHINE    = 2'b11
   } privilege_level_t;

   typedef enum logic [3:0] {
      CSR_READ_ONLY      = 4'd0,
      CSR_WRITE_AND_READ = 4'd1,
      CSR_WRITE_ONLY     = 4'd2,
      CSR_SET            = 4'd3,
      CSR_CLEAR          = 4'd4
   } csr_command_t;

   typedef enum logic [11:0] {
      CSR_MSTATUS    = 12'h300,
      CSR_MISA       = 12'h301,
      CSR_MEDELEG    = 12'h302,
      CSR_MIDELEG    = 12'h303,
      CSR_MIE        = 12'h304,
      CSR_MTVEC      = 12'h305,
      CSR_MCOUNTEREN = 12'h306,
      CSR_MSCRATCH   = 12'h340,
      CSR_MEPC       = 12'h341,
      CSR_MCAUSE     = 12'h342,
      CSR_MTVAL      = 12'h343,
      CSR_MIP        = 12'h344,
      CSR_MTINST     = 12'h34A,
      CSR_MTVAL2     = 12'h34B
   } csr_allocation_t;

   typedef struct packed {
      logic        sd;
      logic [26:0] wpri4;
      logic [1:0]  sxl;
      logic [1:0]  uxl;
      logic [8:0]  wpri3;
      logic        tsr;
      logic        tw;
      logic        tvm;
      logic        mxr;
      logic        sum;
      logic        mprv;
      logic [1:0]  xs;
      logic [1:0]  fs;
      logic [1:0]  mpp;
      logic [1:0]  vs;
      logic        spp;
      logic        mpie;
      logic        ube;
      logic        spie;
      logic        wpri2;
      logic        mie;
      logic        wpri1;
      logic        sie;
      logic        wpri0;
   } mstatus_t;

   typedef struct packed {
      logic [51:0] wpri_hi;
      logic        meie;
      logic        wpri10;
      logic        seie;
      logic        wpri8;
      logic        mtie;
      logic        wpri6;
      logic        stie;
      logic        wpri4;
      logic        msie;
      logic        wpri2;
      logic        ssie;
      logic        wpri0;
   } mie_t;

   typedef struct packed {
      logic [51:0] wpri_hi;
      logic        meip;
      logic        wpri10;
      logic        seip;
      logic        wpri8;
      logic        mtip;
      logic        wpri6;
      logic        stip;
      logic        wpri4;
      logic        msip;
      logic        wpri2;
      logic        ssip;
      logic        wpri0;
   } mip_t;

   typedef struct packed {
      logic [61:0] base;
      logic [1:0]  mode;
   } mtvec_t;

   typedef struct packed {
      logic        interrupt;
      logic [62:0] code;
   } mcause_t;

   // mstatus: mie, mpie, mpp. mie CSR: msie, mtie, meie.
   localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
   localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0888;

endpackage

// File: rtl/csr_warl_legalise.sv
// Combinational WARL legalisation: maps a proposed CSR value onto what the register may hold.
module csr_warl_legalise
   import riscv_privileged_pkg::*;
(
   input  logic [11:0] addr_i,
   input  logic [63:0] old_i,
   input  logic [63:0] new_i,
   output logic [63:0] legal_o
);

   always_comb begin
      legal_o = new_i;
      case (addr_i)
         CSR_MSTATUS: begin
            legal_o = (old_i & ~MSTATUS_WMASK) | (new_i & MSTATUS_WMASK);
            // Supervisor and reserved privilege encodings are not supported in mpp
            if ((new_i[12:11] == 2'b10) || (new_i[12:11] == 2'b01)) begin
               legal_o[12:11] = old_i[12:11];
            end
         end
         CSR_MTVEC: begin
            if (new_i[1:0] >= 2'd2) begin
               legal_o[1:0] = old_i[1:0];
            end
         end
         CSR_MEPC: legal_o[1:0] = 2'b00;
         CSR_MISA, CSR_MEDELEG, CSR_MIDELEG, CSR_MIP: legal_o = old_i;
         CSR_MIE: legal_o = (old_i & ~MIE_WMASK) | (new_i & MIE_WMASK);
         default: legal_o = new_i;
      endcase
   end

endmodule

// File: rtl/m_mode_csr_responder.sv
// M-mode CSR responder and trap-state holder: one request in flight, registered response.
// Define CSR_MTINST_MTVAL2_EN to implement mtinst (0x34A) and mtval2 (0x34B).
module m_mode_csr_responder
   import riscv_privileged_pkg::*;
#(
   parameter logic [63:0] RESET_MTVEC = 64'h0,
   parameter logic [25:0] MISA_EXT    = 26'h101100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [11:0] req_addr_i,
   input  logic [3:0]  req_cmd_i,
   input  logic [63:0] req_wdata_i,
   input  logic [1:0]  req_priv_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rdata_o,
   output logic        rsp_illegal_o,
   input  logic        trap_valid_i,
   input  logic [63:0] trap_cause_i,
   input  logic [63:0] trap_pc_i,
   input  logic [63:0] trap_tval_i,
   input  logic        mret_i,
   input  logic [2:0]  irq_i,
   output logic [1:0]  priv_o,
   output logic [63:0] mstatus_o,
   output logic [63:0] mtvec_o,
   output logic [63:0] mepc_o,
   output logic [63:0] mie_o
);

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   localparam logic [63:0] MISA_VALUE = {2'b10, 36'b0, MISA_EXT};

   state_t      state_q, state_d;
   logic [1:0]  priv_q, priv_d;
   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [1:0]  mstatus_mpp_q, mstatus_mpp_d;
   logic [63:0] mie_q, mie_d;
   mtvec_t      mtvec_q, mtvec_d;
   logic [63:0] mcounteren_q, mcounteren_d;
   logic [63:0] mscratch_q, mscratch_d;
   logic [63:0] mepc_q, mepc_d;
   mcause_t     mcause_q, mcause_d;
   logic [63:0] mtval_q, mtval_d;
`ifdef CSR_MTINST_MTVAL2_EN
   logic [63:0] mtinst_q, mtinst_d;
   logic [63:0] mtval2_q, mtval2_d;
`endif
   logic [63:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_illegal_q, rsp_illegal_d;

   mstatus_t    mstatus_value;
   mip_t        mip_value;
   logic [63:0] old_value;
   logic [63:0] new_value;
   logic [63:0] legal_value;
   logic        implemented;
   logic        cmd_valid;
   logic        write_occurs;
   logic        illegal;
   logic        accept;

   always_comb begin
      mstatus_value      = '0;
      mstatus_value.uxl  = 2'b10;
      mstatus_value.mpp  = mstatus_mpp_q;
      mstatus_value.mpie = mstatus_mpie_q;
      mstatus_value.mie  = mstatus_mie_q;
      mip_value          = '0;
      mip_value.meip     = irq_i[2];
      mip_value.mtip     = irq_i[1];
      mip_value.msip     = irq_i[0];
   end

   always_comb begin
      old_value   = '0;
      implemented = 1'b1;
      case (req_addr_i)
         CSR_MSTATUS:             old_value = mstatus_value;
         CSR_MISA:                old_value = MISA_VALUE;
         CSR_MEDELEG, CSR_MIDELEG: old_value = '0;
         CSR_MIE:                 old_value = mie_q;
         CSR_MTVEC:               old_value = mtvec_q;
         CSR_MCOUNTEREN:          old_value = mcounteren_q;
         CSR_MSCRATCH:            old_value = mscratch_q;
         CSR_MEPC:                old_value = mepc_q;
         CSR_MCAUSE:              old_value = mcause_q;
         CSR_MTVAL:               old_value = mtval_q;
         CSR_MIP:                 old_value = mip_value;
`ifdef CSR_MTINST_MTVAL2_EN
         CSR_MTINST:              old_value = mtinst_q;
         CSR_MTVAL2:              old_value = mtval2_q;
`endif
         default:                 implemented = 1'b0;
      endcase
   end

   always_comb begin
      cmd_valid    = 1'b1;
      write_occurs = 1'b0;
      new_value    = old_value;
      case (req_cmd_i)
         CSR_READ_ONLY: write_occurs = 1'b0;
         CSR_WRITE_AND_READ, CSR_WRITE_ONLY: begin
            write_occurs = 1'b1;
            new_value    = req_wdata_i;
         end
         CSR_SET: begin
            write_occurs = (req_wdata_i != '0);
            new_value    = old_value | req_wdata_i;
         end
         CSR_CLEAR: begin
            write_occurs = (req_wdata_i != '0);
            new_value    = old_value & ~req_wdata_i;
         end
         default: cmd_valid = 1'b0;
      endcase
      illegal = ~implemented | ~cmd_valid | (req_priv_i < req_addr_i[9:8])
              | ((req_addr_i[11:10] == 2'b11) & write_occurs);
   end

   csr_warl_legalise u_legalise (
      .addr_i  (req_addr_i),
      .old_i   (old_value),
      .new_i   (new_value),
      .legal_o (legal_value)
   );

   // Trap/MRET strobes stall new requests so they never collide with a CSR commit
   assign req_ready_o = (state_q == ST_IDLE) & ~trap_valid_i & ~mret_i;
   assign accept      = req_valid_i & req_ready_o;

   always_comb begin
      state_d        = state_q;
      priv_d         = priv_q;
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mstatus_mpp_d  = mstatus_mpp_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mcounteren_d   = mcounteren_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
`ifdef CSR_MTINST_MTVAL2_EN
      mtinst_d       = mtinst_q;
      mtval2_d       = mtval2_q;
`endif
      rsp_rdata_d    = rsp_rdata_q;
      rsp_illegal_d  = rsp_illegal_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d       = ST_RESP;
               rsp_illegal_d = illegal;
               rsp_rdata_d   = (illegal || (req_cmd_i == CSR_WRITE_ONLY)) ? '0 : old_value;
               if (!illegal && write_occurs) begin
                  case (req_addr_i)
                     CSR_MSTATUS: begin
                        mstatus_mie_d  = legal_value[3];
                        mstatus_mpie_d = legal_value[7];
                        mstatus_mpp_d  = legal_value[12:11];
                     end
                     CSR_MIE:        mie_d        = legal_value;
                     CSR_MTVEC:      mtvec_d      = legal_value;
                     CSR_MCOUNTEREN: mcounteren_d = legal_value;
                     CSR_MSCRATCH:   mscratch_d   = legal_value;
                     CSR_MEPC:       mepc_d       = legal_value;
                     CSR_MCAUSE:     mcause_d     = legal_value;
                     CSR_MTVAL:      mtval_d      = legal_value;
`ifdef CSR_MTINST_MTVAL2_EN
                     CSR_MTINST:     mtinst_d     = legal_value;
                     CSR_MTVAL2:     mtval2_d     = legal_value;
`endif
                     default: ;
                  endcase
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (trap_valid_i) begin
         mepc_d         = {trap_pc_i[63:2], 2'b00};
         mcause_d       = trap_cause_i;
         mtval_d        = trap_tval_i;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
         mstatus_mpp_d  = priv_q;
         priv_d         = PRIV_MACHINE;
`ifdef CSR_MTINST_MTVAL2_EN
         mtinst_d       = '0;
         mtval2_d       = '0;
`endif
      end else if (mret_i) begin
         priv_d         = mstatus_mpp_q;
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
         mstatus_mpp_d  = PRIV_USER;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         priv_q         <= PRIV_MACHINE;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mstatus_mpp_q  <= 2'b00;
         mie_q          <= '0;
         mtvec_q        <= RESET_MTVEC;
         mcounteren_q   <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
`ifdef CSR_MTINST_MTVAL2_EN
         mtinst_q       <= '0;
         mtval2_q       <= '0;
`endif
         rsp_rdata_q    <= '0;
         rsp_illegal_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         priv_q         <= priv_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mstatus_mpp_q  <= mstatus_mpp_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mcounteren_q   <= mcounteren_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
`ifdef CSR_MTINST_MTVAL2_EN
         mtinst_q       <= mtinst_d;
         mtval2_q       <= mtval2_d;
`endif
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_illegal_q  <= rsp_illegal_d;
      end
   end

   assign rsp_valid_o   = (state_q == ST_RESP);
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_illegal_o = rsp_illegal_q;
   assign priv_o        = priv_q;
   assign mstatus_o     = mstatus_value;
   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;
   assign mie_o         = mie_q;

endmodule

// File: tb/tb_m_mode_csr_responder.sv
// Directed bench for m_mode_csr_responder: CSR accesses, WARL rules, trap/MRET and handshake hold.
module tb_m_mode_csr_responder;
   import riscv_privileged_pkg::*;

   localparam logic [63:0] TB_RESET_MTVEC = 64'h0000_0000_8000_0101;
   localparam logic [63:0] MISA_EXPECT    = 64'h8000_0000_0010_1100;

   logic        clk_i;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [11:0] req_addr_i;
   logic [3:0]  req_cmd_i;
   logic [63:0] req_wdata_i;
   logic [1:0]  req_priv_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [63:0] rsp_rdata_o;
   logic        rsp_illegal_o;
   logic        trap_valid_i;
   logic [63:0] trap_cause_i;
   logic [63:0] trap_pc_i;
   logic [63:0] trap_tval_i;
   logic        mret_i;
   logic [2:0]  irq_i;
   logic [1:0]  priv_o;
   logic [63:0] mstatus_o;
   logic [63:0] mtvec_o;
   logic [63:0] mepc_o;
   logic [63:0] mie_o;

   int testCount = 0;
   int failCount = 0;
   logic [63:0] rdata;
   logic        illegal;

   m_mode_csr_responder #(
      .RESET_MTVEC (TB_RESET_MTVEC),
      .MISA_EXT    (26'h101100)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_addr_i    (req_addr_i),
      .req_cmd_i     (req_cmd_i),
      .req_wdata_i   (req_wdata_i),
      .req_priv_i    (req_priv_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_illegal_o (rsp_illegal_o),
      .trap_valid_i  (trap_valid_i),
      .trap_cause_i  (trap_cause_i),
      .trap_pc_i     (trap_pc_i),
      .trap_tval_i   (trap_tval_i),
      .mret_i        (mret_i),
      .irq_i         (irq_i),
      .priv_o        (priv_o),
      .mstatus_o     (mstatus_o),
      .mtvec_o       (mtvec_o),
      .mepc_o        (mepc_o),
      .mie_o         (mie_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One complete request/response handshake; the response is expected one cycle after acceptance.
   task automatic applyStimulus(input logic [11:0] addr, input logic [3:0] cmd, input logic [63:0] wdata,
                                input logic [1:0] priv, output logic [63:0] rd, output logic ill);
      @(negedge clk_i);
      checkOutput("req_ready_idle", {63'b0, req_ready_o}, 64'd1);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_cmd_i   = cmd;
      req_wdata_i = wdata;
      req_priv_i  = priv;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      checkOutput("rsp_valid", {63'b0, rsp_valid_o}, 64'd1);
      rd  = rsp_rdata_o;
      ill = rsp_illegal_o;
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
   endtask

   task automatic applyTrap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                            input logic withMret);
      @(negedge clk_i);
      trap_valid_i = 1'b1;
      trap_cause_i = cause;
      trap_pc_i    = pc;
      trap_tval_i  = tval;
      mret_i       = withMret;
      #1;
      checkOutput("ready_low_trap", {63'b0, req_ready_o}, 64'd0);
      @(posedge clk_i);
      #1;
      trap_valid_i = 1'b0;
      mret_i       = 1'b0;
   endtask

   task automatic applyMret();
      @(negedge clk_i);
      mret_i = 1'b1;
      #1;
      checkOutput("ready_low_mret", {63'b0, req_ready_o}, 64'd0);
      @(posedge clk_i);
      #1;
      mret_i = 1'b0;
   endtask

   initial begin
      rst_i        = 1'b1;
      req_valid_i  = 1'b0;
      req_addr_i   = '0;
      req_cmd_i    = '0;
      req_wdata_i  = '0;
      req_priv_i   = '0;
      rsp_ready_i  = 1'b0;
      trap_valid_i = 1'b0;
      trap_cause_i = '0;
      trap_pc_i    = '0;
      trap_tval_i  = '0;
      mret_i       = 1'b0;
      irq_i        = 3'b000;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;

      checkOutput("reset_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
      checkOutput("reset_rdata", rsp_rdata_o, 64'd0);
      checkOutput("reset_priv", {62'b0, priv_o}, 64'd3);
      checkOutput("reset_mtvec", mtvec_o, TB_RESET_MTVEC);
      checkOutput("reset_mstatus", mstatus_o, 64'h0000_0002_0000_0000);
      checkOutput("reset_mie", mie_o, 64'd0);

      applyStimulus(CSR_MTVEC, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("read_mtvec", rdata, TB_RESET_MTVEC);
      checkOutput("read_mtvec_ill", {63'b0, illegal}, 64'd0);
      applyStimulus(CSR_MISA, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("read_misa", rdata, MISA_EXPECT);
      checkOutput("read_misa_ill", {63'b0, illegal}, 64'd0);

      applyStimulus(CSR_MSCRATCH, CSR_WRITE_AND_READ, 64'hDEAD_BEEF, PRIV_MACHINE, rdata, illegal);
      checkOutput("mscratch_wr_old", rdata, 64'd0);
      applyStimulus(CSR_MSCRATCH, CSR_SET, 64'hF00, PRIV_MACHINE, rdata, illegal);
      checkOutput("mscratch_set_old", rdata, 64'hDEAD_BEEF);
      applyStimulus(CSR_MSCRATCH, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("mscratch_final", rdata, 64'hDEAD_BFEF);

      applyStimulus(CSR_MSTATUS, CSR_READ_ONLY, 64'd0, PRIV_USER, rdata, illegal);
      checkOutput("user_mstatus_ill", {63'b0, illegal}, 64'd1);
      checkOutput("user_mstatus_rd", rdata, 64'd0);
      applyStimulus(12'h345, CSR_WRITE_ONLY, 64'h1234, PRIV_MACHINE, rdata, illegal);
      checkOutput("unimpl_345_ill", {63'b0, illegal}, 64'd1);
      applyStimulus(CSR_MISA, CSR_CLEAR, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("clear_misa_ill", {63'b0, illegal}, 64'd0);
      checkOutput("clear_misa_rd", rdata, MISA_EXPECT);
      applyStimulus(CSR_MISA, CSR_WRITE_ONLY, 64'hFFFF, PRIV_MACHINE, rdata, illegal);
      checkOutput("wo_misa_ill", {63'b0, illegal}, 64'd0);
      checkOutput("wo_misa_rd", rdata, 64'd0);
      applyStimulus(CSR_MSCRATCH, 4'hF, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("bad_cmd_ill", {63'b0, illegal}, 64'd1);
      applyStimulus(CSR_MTINST, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
`ifdef CSR_MTINST_MTVAL2_EN
      checkOutput("mtinst_ill", {63'b0, illegal}, 64'd0);
`else
      checkOutput("mtinst_ill", {63'b0, illegal}, 64'd1);
`endif

      // mpie=1, mpp=USER, then MRET drops to USER with mie=1
      applyStimulus(CSR_MSTATUS, CSR_WRITE_AND_READ, 64'h80, PRIV_MACHINE, rdata, illegal);
      checkOutput("mstatus_wr_old", rdata, 64'h0000_0002_0000_0000);
      checkOutput("mstatus_after_wr", mstatus_o, 64'h0000_0002_0000_0080);
      applyMret();
      checkOutput("mret1_priv", {62'b0, priv_o}, 64'd0);
      checkOutput("mret1_mstatus", mstatus_o, 64'h0000_0002_0000_0088);

      applyTrap(64'd2, 64'h1003, 64'h55, 1'b0);
      checkOutput("trap_mepc", mepc_o, 64'h1000);
      checkOutput("trap_priv", {62'b0, priv_o}, 64'd3);
      checkOutput("trap_mstatus", mstatus_o, 64'h0000_0002_0000_0080);
      applyStimulus(CSR_MCAUSE, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("trap_mcause", rdata, 64'd2);
      applyStimulus(CSR_MTVAL, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("trap_mtval", rdata, 64'h55);

      applyMret();
      checkOutput("mret2_priv", {62'b0, priv_o}, 64'd0);
      checkOutput("mret2_mstatus", mstatus_o, 64'h0000_0002_0000_0088);

      applyTrap(64'h8000_0000_0000_0007, 64'h2006, 64'd0, 1'b1);
      checkOutput("trapmret_priv", {62'b0, priv_o}, 64'd3);
      checkOutput("trapmret_mepc", mepc_o, 64'h2004);
      checkOutput("trapmret_mstatus", mstatus_o, 64'h0000_0002_0000_0080);

      // Response held for 5 cycles with a trap landing in the middle
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_addr_i  = CSR_MEPC;
      req_cmd_i   = CSR_READ_ONLY;
      req_wdata_i = '0;
      req_priv_i  = PRIV_MACHINE;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_valid", {63'b0, rsp_valid_o}, 64'd1);
         checkOutput("hold_rdata", rsp_rdata_o, 64'h2004);
         checkOutput("hold_illegal", {63'b0, rsp_illegal_o}, 64'd0);
         checkOutput("hold_ready", {63'b0, req_ready_o}, 64'd0);
         if (i == 1) begin
            trap_valid_i = 1'b1;
            trap_cause_i = 64'd3;
            trap_pc_i    = 64'h3000;
            trap_tval_i  = 64'd0;
         end
         @(posedge clk_i);
         #1;
         trap_valid_i = 1'b0;
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      checkOutput("hold_released", {63'b0, rsp_valid_o}, 64'd0);
      checkOutput("hold_trap_mepc", mepc_o, 64'h3000);
      checkOutput("hold_trap_mstatus", mstatus_o, 64'h0000_0002_0000_1800);

      applyStimulus(CSR_MTVEC, CSR_WRITE_AND_READ, 64'h4000_0003, PRIV_MACHINE, rdata, illegal);
      checkOutput("mtvec_wr_old", rdata, TB_RESET_MTVEC);
      checkOutput("mtvec_mode_kept", mtvec_o, 64'h4000_0001);
      applyStimulus(CSR_MEPC, CSR_WRITE_AND_READ, 64'h1237, PRIV_MACHINE, rdata, illegal);
      checkOutput("mepc_align", mepc_o, 64'h1234);
      applyStimulus(CSR_MSTATUS, CSR_WRITE_AND_READ, 64'h808, PRIV_MACHINE, rdata, illegal);
      checkOutput("mstatus_mpp_old", rdata, 64'h0000_0002_0000_1800);
      checkOutput("mstatus_mpp_kept", mstatus_o, 64'h0000_0002_0000_1808);
      applyStimulus(CSR_MIE, CSR_WRITE_AND_READ, 64'hFFFF_FFFF_FFFF_FFFF, PRIV_MACHINE, rdata, illegal);
      checkOutput("mie_masked", mie_o, 64'h888);
      irq_i = 3'b101;
      applyStimulus(CSR_MIP, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("mip_read", rdata, 64'h808);
      applyStimulus(CSR_MEDELEG, CSR_WRITE_AND_READ, 64'hFF, PRIV_MACHINE, rdata, illegal);
      checkOutput("medeleg_ill", {63'b0, illegal}, 64'd0);
      applyStimulus(CSR_MEDELEG, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("medeleg_zero", rdata, 64'd0);

      // Reset while a response is pending
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_addr_i  = CSR_MSCRATCH;
      req_cmd_i   = CSR_READ_ONLY;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      checkOutput("pre_reset_valid", {63'b0, rsp_valid_o}, 64'd1);
      rst_i = 1'b1;
      #1;
      checkOutput("midreset_valid", {63'b0, rsp_valid_o}, 64'd0);
      checkOutput("midreset_mtvec", mtvec_o, TB_RESET_MTVEC);
      checkOutput("midreset_mie", mie_o, 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      applyStimulus(CSR_MSCRATCH, CSR_READ_ONLY, 64'd0, PRIV_MACHINE, rdata, illegal);
      checkOutput("post_reset_mscratch", rdata, 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
